div_issue_stage: RTL and testbench

DIV_ISSUE_STAGE -- requirements
Module: div_issue_stage

---
 rtl/div_issue_stage.sv | 173 +++++++++++++++++
 tb/tb_div_issue_stage.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_issue_stage.sv
// Issue stage wrapped around a combinational posit divider.
// A 2-entry operand FIFO feeds an operand register that drives the divider.
// A result register captures the quotient and applies special-case overrides.
// in_ready_o depends only on FIFO occupancy and flush_i, so it has no path from out_ready_i.
module div_issue_stage #(
    parameter int unsigned N  = 32,
    parameter int unsigned ES = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [N-1:0] dividend_i,
    input  logic [N-1:0] divisor_i,
    input  logic         flush_i,
    output logic [N-1:0] div_in1_o,
    output logic [N-1:0] div_in2_o,
    input  logic [N-1:0] div_out_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [N-1:0] result_o,
    output logic [1:0]   flags_o
);

    // NaR is the sign bit alone; zero is all bits clear.
    localparam logic [N-1:0] NarVal  = {1'b1, {(N-1){1'b0}}};
    localparam logic [N-1:0] ZeroVal = '0;

    // The divider itself consumes ES; here it only bounds legal configurations.
    if (ES + 3 > N) begin : g_bad_es
        $error("div_issue_stage: ES too large for word width N");
    end

    // Operand FIFO storage and control.
    logic [N-1:0] fifo_a_q [2];
    logic [N-1:0] fifo_b_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   count_q;
    logic [1:0]   count_d;

    // Operand register, which drives the divider inputs.
    logic         op_valid_q;
    logic [N-1:0] op_a_q;
    logic [N-1:0] op_b_q;

    // Result register.
    logic         out_valid_q;
    logic [N-1:0] result_q;
    logic [1:0]   flags_q;

    // Handshake and movement strobes.
    logic         push;
    logic         pop;
    logic         op_adv;
    logic         op_load;

    // Special-case selection for the value being captured.
    logic         a_nar;
    logic         b_nar;
    logic         a_zero;
    logic         b_zero;
    logic [N-1:0] sel_result;
    logic [1:0]   sel_flags;

    assign in_ready_o  = (count_q < 2'd2) && !flush_i;
    assign div_in1_o   = op_a_q;
    assign div_in2_o   = op_b_q;
    assign out_valid_o = out_valid_q;
    assign result_o    = result_q;
    assign flags_o     = flags_q;

    // Movement strobes: the op register drains into the result slot when that slot is free,
    // and refills from the FIFO head in the same cycle.
    always_comb begin
        push    = in_valid_i && in_ready_o;
        op_adv  = op_valid_q && (!out_valid_q || out_ready_i);
        op_load = (count_q != 2'd0) && (!op_valid_q || op_adv);
        pop     = op_load;
    end

    // Next occupancy; push and pop on the same edge cancel out.
    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Special-case override, highest priority first: NaR operand, zero divisor, zero dividend.
    always_comb begin
        a_nar      = (op_a_q == NarVal);
        b_nar      = (op_b_q == NarVal);
        a_zero     = (op_a_q == ZeroVal);
        b_zero     = (op_b_q == ZeroVal);
        sel_result = div_out_i;
        sel_flags  = 2'b00;
        if (a_nar || b_nar) begin
            sel_result = NarVal;
            sel_flags  = 2'b10;
        end else if (b_zero) begin
            sel_result = NarVal;
            sel_flags  = 2'b01;
        end else if (a_zero) begin
            sel_result = ZeroVal;
            sel_flags  = 2'b00;
        end
    end

    // FIFO pointers, occupancy and storage; flush drops every queued pair.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
            fifo_a_q[0] <= '0;
            fifo_a_q[1] <= '0;
            fifo_b_q[0] <= '0;
            fifo_b_q[1] <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                fifo_a_q[wr_ptr_q] <= dividend_i;
                fifo_b_q[wr_ptr_q] <= divisor_i;
                wr_ptr_q           <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

    // Operand register: data holds while the op is stalled so the divider inputs stay stable.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_valid_q <= 1'b0;
            op_a_q     <= '0;
            op_b_q     <= '0;
        end else if (flush_i) begin
            op_valid_q <= 1'b0;
        end else if (op_load) begin
            op_valid_q <= 1'b1;
            op_a_q     <= fifo_a_q[rd_ptr_q];
            op_b_q     <= fifo_b_q[rd_ptr_q];
        end else if (op_adv) begin
            op_valid_q <= 1'b0;
        end
    end

    // Result register: captures on op advance, clears once consumed with nothing behind it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= 2'b00;
        end else if (flush_i) begin
            out_valid_q <= 1'b0;
        end else if (op_adv) begin
            out_valid_q <= 1'b1;
            result_q    <= sel_result;
            flags_q     <= sel_flags;
        end else if (out_ready_i) begin
            out_valid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_div_issue_stage.sv
// Scoreboard bench for div_issue_stage: the driver pushes expected {flags, result} on each
// accepted pair, and a negedge monitor pops and compares on every output transfer.
module tb_div_issue_stage;

    localparam int N = 32;
    localparam logic [N-1:0] ONE = 32'h4000_0000;
    localparam logic [N-1:0] NAR = 32'h8000_0000;

    logic         clk = 1'b0;
    logic         rst_ni = 1'b0;
    logic         in_valid_i = 1'b0;
    logic         in_ready_o;
    logic [N-1:0] dividend_i = '0;
    logic [N-1:0] divisor_i = '0;
    logic         flush_i = 1'b0;
    logic [N-1:0] div_in1_o;
    logic [N-1:0] div_in2_o;
    logic [N-1:0] div_out_i;
    logic         out_valid_o;
    logic         out_ready_i = 1'b0;
    logic [N-1:0] result_o;
    logic [1:0]   flags_o;

    int n_checks = 0;
    int n_fail = 0;
    logic [N+1:0] sb[$];

    always #5 clk = ~clk;

    // Stand-in divider: exact for a divisor of 1.0, otherwise an arbitrary but known mapping.
    function automatic logic [N-1:0] fake_div(input logic [N-1:0] a, input logic [N-1:0] b);
        if (b == ONE) return a;
        return a ^ b;
    endfunction

    assign div_out_i = fake_div(div_in1_o, div_in2_o);

    div_issue_stage #(.N(N), .ES(4)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .dividend_i  (dividend_i),
        .divisor_i   (divisor_i),
        .flush_i     (flush_i),
        .div_in1_o   (div_in1_o),
        .div_in2_o   (div_in2_o),
        .div_out_i   (div_out_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .result_o    (result_o),
        .flags_o     (flags_o)
    );

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Output monitor: every transfer must match the oldest outstanding expectation.
    always @(negedge clk) begin
        logic [N+1:0] e;
        if (rst_ni && out_valid_o && out_ready_i) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got %h, expected no output", result_o);
            end else begin
                e = sb.pop_front();
                check("result", result_o, e[N-1:0]);
                check("flags", {30'd0, flags_o}, {30'd0, e[N+1:N]});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one pair until accepted; must be called just after a rising edge.
    task automatic send(input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [N-1:0] r, input logic [1:0] f);
        int budget;
        budget = 0;
        dividend_i = a;
        divisor_i  = b;
        in_valid_i = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready_o) begin
                sb.push_back({f, r});
                break;
            end
            budget++;
            if (budget > 200) begin
                n_checks++;
                n_fail++;
                $display("FAIL send_timeout: got no acceptance, expected acceptance");
                break;
            end
        end
        step();
        in_valid_i = 1'b0;
    endtask

    task automatic wait_drain();
        int budget;
        budget = 0;
        while (sb.size() != 0 && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending, expected 0", sb.size());
        end
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] bp_a [5];
        logic [N-1:0] hold;
        logic [N-1:0] tp_val;
        int acc;
        int run;
        int best;

        bp_a[0] = 32'h4400_0000;
        bp_a[1] = 32'h4800_0000;
        bp_a[2] = 32'h3C00_0000;
        bp_a[3] = 32'hC400_0000;
        bp_a[4] = 32'h4C00_0000;

        // Reset values while held in reset.
        repeat (2) @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid_o}, 0);
        check("rst_result", result_o, 0);
        check("rst_flags", {30'd0, flags_o}, 0);
        check("rst_div_in1", div_in1_o, 0);
        check("rst_div_in2", div_in2_o, 0);
        rst_ni = 1'b1;
        @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready_o}, 1);
        step();

        // Single op, latency of two edges after acceptance.
        out_ready_i = 1'b1;
        send(32'h4400_0000, ONE, 32'h4400_0000, 2'b00);
        @(negedge clk);
        check("lat_e0", {31'd0, out_valid_o}, 0);
        @(negedge clk);
        check("lat_e1", {31'd0, out_valid_o}, 0);
        check("lat_div_in1", div_in1_o, 32'h4400_0000);
        @(negedge clk);
        check("lat_e2", {31'd0, out_valid_o}, 1);
        wait_drain();

        // Special cases and a general quotient.
        send(32'h4000_0000, 32'h0000_0000, NAR, 2'b01);
        send(32'h0000_0000, 32'h4400_0000, 32'h0000_0000, 2'b00);
        send(NAR, 32'h0000_0000, NAR, 2'b10);
        send(32'h0000_0000, NAR, NAR, 2'b10);
        send(32'h4800_0000, 32'h4400_0000, 32'h0C00_0000, 2'b00);
        wait_drain();

        // Backpressure: five offered, four fit.
        out_ready_i = 1'b0;
        acc = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            if (acc < 5) begin
                in_valid_i = 1'b1;
                dividend_i = bp_a[acc];
                divisor_i  = ONE;
            end
            @(negedge clk);
            if (in_valid_i && in_ready_o && acc < 5) begin
                sb.push_back({2'b00, bp_a[acc]});
                acc++;
            end
            step();
        end
        check("bp_accepted", acc, 4);
        @(negedge clk);
        check("bp_in_ready", {31'd0, in_ready_o}, 0);
        hold = result_o;
        check("bp_head", hold, bp_a[0]);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_stable", result_o, hold);
            check("bp_valid", {31'd0, out_valid_o}, 1);
        end
        step();
        in_valid_i = 1'b0;
        out_ready_i = 1'b1;
        wait_drain();
        send(bp_a[4], ONE, bp_a[4], 2'b00);
        wait_drain();

        // Throughput: eight back-to-back pairs.
        run = 0;
        best = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            tp_val = 32'h4100_0000 + (32'(cyc) << 8);
            in_valid_i = (cyc < 8);
            dividend_i = tp_val;
            divisor_i  = ONE;
            @(negedge clk);
            if (cyc < 8) begin
                check("tp_in_ready", {31'd0, in_ready_o}, 1);
                if (in_ready_o) sb.push_back({2'b00, tp_val});
            end
            if (out_valid_o) begin
                run++;
                if (run > best) best = run;
            end else begin
                run = 0;
            end
            step();
        end
        in_valid_i = 1'b0;
        check("tp_run", best, 8);
        wait_drain();

        // Flush with three pairs in flight.
        out_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) send(bp_a[i], ONE, bp_a[i], 2'b00);
        flush_i = 1'b1;
        sb.delete();
        step();
        flush_i = 1'b0;
        @(negedge clk);
        check("fl_out_valid", {31'd0, out_valid_o}, 0);
        check("fl_in_ready", {31'd0, in_ready_o}, 1);
        step();
        // Empty pipeline must again take exactly four before stalling.
        acc = 0;
        in_valid_i = 1'b1;
        dividend_i = 32'h5000_0000;
        divisor_i  = ONE;
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(negedge clk);
            if (in_ready_o) begin
                sb.push_back({2'b00, 32'h5000_0000});
                acc++;
            end
            step();
        end
        in_valid_i = 1'b0;
        check("fl_capacity", acc, 4);
        out_ready_i = 1'b1;
        wait_drain();

        // Asynchronous reset with a full pipeline.
        out_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) send(bp_a[i], ONE, bp_a[i], 2'b00);
        #2;
        rst_ni = 1'b0;
        sb.delete();
        #1;
        check("ar_out_valid", {31'd0, out_valid_o}, 0);
        check("ar_result", result_o, 0);
        check("ar_flags", {30'd0, flags_o}, 0);
        check("ar_div_in1", div_in1_o, 0);
        check("ar_div_in2", div_in2_o, 0);
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);
        check("ar_in_ready", {31'd0, in_ready_o}, 1);
        step();
        out_ready_i = 1'b1;
        send(32'h4000_0000, 32'h0000_0000, NAR, 2'b01);
        send(32'h4400_0000, ONE, 32'h4400_0000, 2'b00);
        wait_drain();
        repeat (5) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
